// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle barrel-shift sequencer.
// Holds the shift-type codes, the FSM state encoding and the effective-amount rule.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // LSL/LSR saturate at 33 so one extra step clears the carry; ROR 32 is a full turn.
  function automatic logic [5:0] eff_amount(input shift_t t, input logic [7:0] amt);
    logic [5:0] eff;
    case (t)
      SH_LSL, SH_LSR: eff = (amt > 8'd33) ? 6'd33 : amt[5:0];
      SH_ASR:         eff = (amt > 8'd32) ? 6'd32 : amt[5:0];
      default:        eff = ((amt[4:0] == 5'd0) && (amt != 8'd0)) ? 6'd32 : {1'b0, amt[4:0]};
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the value by 0..STEP positions.
// Carry path exists only when SHIFT_SEQ_CARRY_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic [31:0]                  value_i,
  input  shift_t                       type_i,
  input  logic [$clog2(STEP+1)-1:0]    count_i,
  input  logic                         carry_i,
  output logic [31:0]                  value_o,
  output logic                         carry_o
);

  logic [5:0] cnt6;
  assign cnt6 = 6'(count_i);

  always_comb begin
    value_o = value_i;
    if (cnt6 != 6'd0) begin
      case (type_i)
        SH_LSL:  value_o = value_i << cnt6;
        SH_LSR:  value_o = value_i >> cnt6;
        SH_ASR:  value_o = 32'($signed(value_i) >>> cnt6);
        default: value_o = (value_i >> cnt6) | (value_i << (6'd32 - cnt6));
      endcase
    end
  end

`ifdef SHIFT_SEQ_CARRY_EN
  logic [4:0] hi_idx, lo_idx;
  assign hi_idx = 5'(6'd32 - cnt6);
  assign lo_idx = 5'(cnt6 - 6'd1);

  always_comb begin
    carry_o = carry_i;
    if (cnt6 != 6'd0) begin
      if (type_i == SH_LSL) carry_o = value_i[hi_idx];
      else                  carry_o = value_i[lo_idx];
    end
  end
`else
  logic unused_carry_i;
  assign unused_carry_i = carry_i;
  assign carry_o = 1'b0;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM register-shift sequencer, STEP positions per RUN cycle.
// Optional macro SHIFT_SEQ_CARRY_EN enables the carry register and carry-out.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | shifting, remaining count > 0
//   DONE    | result valid, done pulse; can accept a new start
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [31:0] val_rm,
  input  logic [7:0]  amount,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam int CW = $clog2(STEP + 1);

  state_t        state_q, state_d;
  shift_t        type_q;
  logic [31:0]   val_q, result_q, step_val;
  logic [5:0]    rem_q, eff;
  logic [CW-1:0] step_cnt;
  logic          accept, last_step, step_cin, step_carry;

  assign eff       = eff_amount(shift_t'(shift_type), amount);
  assign accept    = ~rst & start & ~flush & (state_q != ST_RUN);
  assign last_step = (rem_q <= 6'(STEP));
  assign step_cnt  = last_step ? CW'(rem_q) : CW'(STEP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN:  if (last_step) state_d = ST_DONE;
        default: if (start) state_d = (eff == 6'd0) ? ST_DONE : ST_RUN;
                 else       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q == ST_RUN);
    done  = (state_q == ST_DONE);
    stall = accept | (state_q == ST_RUN);
  end

  // Working value is kept apart from result so a flush leaves the last result intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= '0;
      type_q   <= SH_LSL;
      rem_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      val_q  <= val_rm;
      type_q <= shift_t'(shift_type);
      rem_q  <= eff;
      if (eff == 6'd0) result_q <= val_rm;
    end else if (!flush && state_q == ST_RUN) begin
      val_q <= step_val;
      rem_q <= rem_q - 6'(step_cnt);
      if (last_step) result_q <= step_val;
    end
  end

  assign result = result_q;

`ifdef SHIFT_SEQ_CARRY_EN
  logic cin_q, carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cin_q <= carry_in;
      if (eff == 6'd0) carry_q <= carry_in;
    end else if (!flush && state_q == ST_RUN) begin
      cin_q <= step_carry;
      if (last_step) carry_q <= step_carry;
    end
  end

  assign step_cin  = cin_q;
  assign carry_out = carry_q;
`else
  logic unused_carry;
  assign unused_carry = carry_in ^ step_carry;
  assign step_cin     = 1'b0;
  assign carry_out    = 1'b0;
`endif

  shift_step #(.STEP(STEP)) u_step (
    .value_i (val_q),
    .type_i  (type_q),
    .count_i (step_cnt),
    .carry_i (step_cin),
    .value_o (step_val),
    .carry_o (step_carry)
  );

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 8, max shift positions per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request a register-specified shift; sampled only when accepting.
REQ-005 SHALL have port flush  in  1  synchronous abort of the operation in flight.
REQ-006 SHALL have port shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 SHALL have port val_rm  in  32  operand to shift.
REQ-008 SHALL have port amount  in  8  shift amount, Rs[7:0].
REQ-009 SHALL have port carry_in  in  1  current C flag.
REQ-010 SHALL have port busy  out  1  operation in progress (state RUN).
REQ-011 SHALL have port done  out  1  one-cycle pulse; result valid.
REQ-012 SHALL have port stall  out  1  combinational start-accepted OR busy; freezes the pipeline.
REQ-013 SHALL have port result  out  32  shifted value.
REQ-014 SHALL have port carry_out  out  1  shifter carry-out.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; flush or rst in any state forces IDLE.
REQ-016 SHALL accept start in IDLE or DONE (back-to-back allowed); start in RUN SHALL be ignored.
REQ-017 On accept, SHALL latch val_rm, shift_type, carry_in, and effective amount E.
- LSL/LSR: E = min(amount, 33).
- ASR: E = min(amount, 32).
- ROR: E = amount[4:0], or 32 if amount != 0 and amount[4:0] == 0.
REQ-018 Each RUN cycle SHALL shift by min(remaining, STEP) and decrement remaining by that count.
- carry SHALL equal the last bit shifted out: LSL shifts zeros in; LSR shifts zeros in; ASR replicates bit 31; ROR rotates.
REQ-019 With N = ceil(E/STEP), RUN SHALL last exactly N cycles; done SHALL assert N+1 cycles after the accepting edge.
- E = 0: RUN SHALL be skipped; done SHALL assert next cycle with result = val_rm and carry_out = carry_in.
REQ-020 result and carry_out SHALL hold their values after done until the next accepted start completes.
REQ-021 flush SHALL take priority over start in the same cycle; a flushed operation SHALL never produce done.
- result and carry_out SHALL keep their last completed values after a flush.
REQ-022 Stepwise shifting SHALL reproduce ARM register-shift semantics: LSL/LSR by 32 give 0 with carry bit0/bit31; by >32 give 0 with carry 0; ASR >= 32 gives sign fill with carry bit31; ROR by 32 gives val_rm with carry bit31.

Reset
REQ-023 rst SHALL set state IDLE, busy 0, done 0, result 0, carry_out 0, and the remaining-count register 0.
REQ-024 rst SHALL override flush and start, including mid-RUN; no done SHALL follow reset.

Configuration
REQ-025 Macro SHIFT_SEQ_CARRY_EN: when defined, carry_out SHALL follow REQ-018/019/022.
- When undefined, carry_out SHALL be constant 0, and no carry register or carry logic SHALL be present.

Structure
REQ-026 Package shift_pkg SHALL hold the shift_type codes (LSL/LSR/ASR/ROR) and the FSM state enum.
REQ-027 Sub-module shift_step SHALL be a combinational one-step shifter: inputs value, type, count 0..STEP, carry; outputs value and carry. It SHALL be instantiated once.

Verification
REQ-028 LSL, val_rm 0x00000001, amount 4, STEP 8 -> done at cycle 2, result 0x00000010, carry_out 0.
REQ-029 LSR, val_rm 0x80000001, amount 33 -> 5 RUN cycles, done at cycle 6, result 0, carry_out 0; with amount 32 -> result 0, carry_out 1.
REQ-030 ASR, val_rm 0x80000000, amount 40 -> E 32, done at cycle 5, result 0xFFFFFFFF, carry_out 1.
REQ-031 ROR, val_rm 0x0000000F, amount 4 -> result 0xF0000000, carry_out 1; ROR, val_rm 0x80000001, amount 64 -> result 0x80000001, carry_out 1.
REQ-032 Any type, amount 0, carry_in 1 -> done at cycle 1, result = val_rm, carry_out 1, busy never high.
REQ-033 Start LSL amount 32, then flush at RUN cycle 2 -> IDLE, no done, previous result held; start during RUN ignored; rst mid-RUN -> all outputs 0 next cycle.
